// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared select codes, field enum and read FSM state for the n-body host bridge
package nbody_pkg;

  localparam int SEL_W = 7;

  localparam logic [SEL_W-1:0] SEL_GO         = 7'h00;
  localparam logic [SEL_W-1:0] SEL_READ       = 7'h01;
  localparam logic [SEL_W-1:0] SEL_N_BODIES   = 7'h02;
  localparam logic [SEL_W-1:0] SEL_GAP        = 7'h03;
  localparam logic [SEL_W-1:0] SEL_FIELD_BASE = 7'h04;
  localparam logic [SEL_W-1:0] SEL_DONE       = 7'h40;
  localparam logic [SEL_W-1:0] SEL_OUT_BASE   = 7'h41;
  localparam logic [SEL_W-1:0] SEL_STATUS     = 7'h7F;

  typedef enum logic [2:0] {
    FIELD_X  = 3'd0,
    FIELD_Y  = 3'd1,
    FIELD_M  = 3'd2,
    FIELD_VX = 3'd3,
    FIELD_VY = 3'd4
  } field_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_FETCH = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nbody_half_word_stager.sv
// rtl/nbody_half_word_stager.sv - pairs lower/upper half writes into one field-memory commit
module nbody_half_word_stager #(
  parameter int FIELD_W = 3,
  parameter int IDX_W   = 9,
  parameter int HALF_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lo_we,
  input  logic                hi_we,
  input  logic [FIELD_W-1:0]  field,
  input  logic [IDX_W-1:0]    idx,
  input  logic [HALF_W-1:0]   data,
  output logic                stage_valid,
  output logic                mismatch,
  output logic                commit,
  output logic [FIELD_W-1:0]  commit_field,
  output logic [IDX_W-1:0]    commit_idx,
  output logic [2*HALF_W-1:0] commit_data
);
  logic [FIELD_W-1:0] st_field;
  logic [IDX_W-1:0]   st_idx;
  logic [HALF_W-1:0]  st_lo;
  logic               match;

  // An upper half only pairs with a staged lower half for the same field and body
  assign match    = stage_valid && (field == st_field) && (idx == st_idx);
  assign mismatch = hi_we && !match;

  // Stage lower halves; on a matching upper half emit a one-cycle commit of {hi, lo}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid  <= 1'b0;
      st_field     <= '0;
      st_idx       <= '0;
      st_lo        <= '0;
      commit       <= 1'b0;
      commit_field <= '0;
      commit_idx   <= '0;
      commit_data  <= '0;
    end else begin
      commit <= 1'b0;
      if (lo_we) begin
        stage_valid <= 1'b1;
        st_field    <= field;
        st_idx      <= idx;
        st_lo       <= data;
      end else if (hi_we && match) begin
        stage_valid  <= 1'b0;
        commit       <= 1'b1;
        commit_field <= st_field;
        commit_idx   <= st_idx;
        commit_data  <= {data, st_lo};
      end
    end
  end

endmodule

// File: rtl/nbody_host_bridge.sv
// rtl/nbody_host_bridge.sv - host register/memory bridge for the n-body core
module nbody_host_bridge
  import nbody_pkg::*;
#(
  parameter int BUS_W       = 32,
  parameter int WORD_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int BODY_ADDR_W = 9,
  parameter int NUM_FIELDS  = 5,
  parameter int NUM_OUT     = 2,
  parameter int RD_TIMEOUT  = 255,
  localparam int FIELD_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int OUT_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic                   read,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [BUS_W-1:0]       writedata,
  output logic [BUS_W-1:0]       readdata,
  output logic                   waitrequest,
  output logic                   mem_we,
  output logic [FIELD_W-1:0]     mem_field,
  output logic [BODY_ADDR_W-1:0] mem_idx,
  output logic [WORD_W-1:0]      mem_wdata,
  output logic                   go,
  output logic                   freeze,
  output logic [BODY_ADDR_W:0]   n_bodies,
  output logic [BUS_W-1:0]       gap,
  output logic                   rd_req,
  output logic [OUT_W-1:0]       rd_field,
  output logic [BODY_ADDR_W-1:0] rd_idx,
  input  logic                   rd_valid,
  input  logic [WORD_W-1:0]      rd_data,
  input  logic                   core_done
);
  localparam int NB_W   = BODY_ADDR_W + 1;
  localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);
  localparam int NB_MAX = 1 << BODY_ADDR_W;

  logic [SEL_W-1:0]       sel, f_off, o_off;
  logic [BODY_ADDR_W-1:0] idx;
  logic                   wr, rd, field_sel, out_sel, fw_upper, out_upper;
  logic [FIELD_W-1:0]     fw_field;
  logic [OUT_W-1:0]       out_k;
  logic                   lo_we, hi_we, fld_blocked, stg_mismatch, stage_valid;
  logic                   out_rd, lat_hit, oor, out_resp, rd_acc, go_rise, tmo_hit, err_inc;
  logic                   done_sticky, timed_out;
  logic [7:0]             err_cnt;
  logic [BUS_W-1:0]       rd_mux;
  logic [TMO_W-1:0]       cnt;
  rd_state_e              state;
  logic                   lat_valid;
  logic [OUT_W-1:0]       lat_field;
  logic [BODY_ADDR_W-1:0] lat_idx;
  logic [WORD_W-1:0]      lat_word;

  assign sel       = SEL_W'(addr >> BODY_ADDR_W);
  assign idx       = addr[BODY_ADDR_W-1:0];
  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign f_off     = sel - SEL_FIELD_BASE;
  assign o_off     = sel - SEL_OUT_BASE;
  assign field_sel = (sel >= SEL_FIELD_BASE) && (sel < SEL_FIELD_BASE + SEL_W'(2 * NUM_FIELDS));
  assign out_sel   = (sel >= SEL_OUT_BASE) && (sel < SEL_OUT_BASE + SEL_W'(2 * NUM_OUT));
  assign fw_field  = FIELD_W'(f_off >> 1);
  assign fw_upper  = f_off[0];
  assign out_k     = OUT_W'(o_off >> 1);
  assign out_upper = o_off[0];

  // Body memories must not change under a running core, so field writes are refused while go=1
  assign fld_blocked = wr & field_sel & go;
  assign lo_we       = wr & field_sel & ~go & ~fw_upper;
  assign hi_we       = wr & field_sel & ~go & fw_upper;

  assign out_rd   = rd & out_sel;
  assign lat_hit  = lat_valid && (lat_field == out_k) && (lat_idx == idx);
  assign oor      = {1'b0, idx} >= n_bodies;
  assign out_resp = lat_hit | oor | timed_out;
  assign waitrequest = (state == RD_FETCH) || (out_rd && !out_resp);
  assign rd_acc   = rd & ~waitrequest;
  assign go_rise  = wr && (sel == SEL_GO) && writedata[0] && !go;
  assign tmo_hit  = (state == RD_FETCH) && !rd_valid && (cnt == TMO_W'(RD_TIMEOUT - 1));
  assign err_inc  = stg_mismatch | fld_blocked | tmo_hit;

  nbody_half_word_stager #(
    .FIELD_W (FIELD_W),
    .IDX_W   (BODY_ADDR_W),
    .HALF_W  (BUS_W)
  ) u_stager (
    .clk          (clk),
    .rst          (rst),
    .lo_we        (lo_we),
    .hi_we        (hi_we),
    .field        (fw_field),
    .idx          (idx),
    .data         (writedata),
    .stage_valid  (stage_valid),
    .mismatch     (stg_mismatch),
    .commit       (mem_we),
    .commit_field (mem_field),
    .commit_idx   (mem_idx),
    .commit_data  (mem_wdata)
  );

  // Readback mux; out reads return the latched word only on a hit, otherwise zero
  always_comb begin
    rd_mux = '0;
    if (sel == SEL_DONE) begin
      rd_mux[0] = done_sticky;
    end else if (sel == SEL_STATUS) begin
      rd_mux[10:0] = {err_cnt, stage_valid, freeze, go};
    end else if (out_sel && lat_hit) begin
      rd_mux = out_upper ? lat_word[WORD_W-1:BUS_W] : lat_word[BUS_W-1:0];
    end
  end

  // Control registers, sticky done flag and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go          <= 1'b0;
      freeze      <= 1'b0;
      n_bodies    <= '0;
      gap         <= '0;
      done_sticky <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (wr && (sel == SEL_GO)) begin
        go <= writedata[0];
        if (writedata[0]) done_sticky <= 1'b0;
      end
      if (core_done) done_sticky <= 1'b1;
      if (wr && (sel == SEL_READ)) freeze <= writedata[0];
      if (wr && (sel == SEL_N_BODIES))
        n_bodies <= (writedata > BUS_W'(NB_MAX)) ? NB_W'(NB_MAX) : NB_W'(writedata);
      if (wr && (sel == SEL_GAP)) gap <= writedata;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Read FSM: serve hits from the result latch, fetch misses from the core, give up after RD_TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RD_IDLE;
      rd_req    <= 1'b0;
      rd_field  <= '0;
      rd_idx    <= '0;
      cnt       <= '0;
      timed_out <= 1'b0;
      readdata  <= '0;
      lat_valid <= 1'b0;
      lat_field <= '0;
      lat_idx   <= '0;
      lat_word  <= '0;
    end else begin
      rd_req <= 1'b0;
      if (core_done || go_rise) lat_valid <= 1'b0;
      if (rd_acc) readdata <= rd_mux;
      case (state)
        RD_IDLE: begin
          timed_out <= 1'b0;
          if (out_rd && !out_resp) begin
            state    <= RD_FETCH;
            rd_req   <= 1'b1;
            rd_field <= out_k;
            rd_idx   <= idx;
            cnt      <= '0;
          end
        end
        RD_FETCH: begin
          if (rd_valid && core_done) begin
            // The response belongs to the superseded snapshot: ask again
            rd_req <= 1'b1;
            cnt    <= '0;
          end else if (rd_valid) begin
            lat_valid <= 1'b1;
            lat_field <= rd_field;
            lat_idx   <= rd_idx;
            lat_word  <= rd_data;
            state     <= RD_IDLE;
          end else if (tmo_hit) begin
            timed_out <= 1'b1;
            state     <= RD_IDLE;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbody_host_bridge.sv
// tb/tb_nbody_host_bridge.sv - self-checking bench for nbody_host_bridge
module tb_nbody_host_bridge;
  localparam int RD_TIMEOUT = 255;

  logic        clk = 1'b0, rst = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest, mem_we;
  logic [2:0]  mem_field;
  logic [8:0]  mem_idx;
  logic [63:0] mem_wdata;
  logic        go, freeze;
  logic [9:0]  n_bodies;
  logic [31:0] gap;
  logic        rd_req;
  logic [0:0]  rd_field;
  logic [8:0]  rd_idx;
  logic        rd_valid = 1'b0;
  logic [63:0] rd_data = '0;
  logic        core_done = 1'b0;

  int n_vec = 0, n_err = 0;

  nbody_host_bridge dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
    .addr(addr), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .mem_we(mem_we), .mem_field(mem_field), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .go(go), .freeze(freeze), .n_bodies(n_bodies), .gap(gap),
    .rd_req(rd_req), .rd_field(rd_field), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Observed commits and fetch requests
  logic [75:0] we_q[$];
  int rdreq_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) we_q.push_back({mem_field, mem_idx, mem_wdata});
    if (rd_req) rdreq_cnt++;
  end

  // Core-side model: result words depend on field, body and snapshot number
  int          resp_delay = 0;
  bit          resp_en = 1'b1, race_once = 1'b0, done_req = 1'b0, fixed_en = 1'b0;
  logic [63:0] fixed_word = '0;
  int          snap = 0;

  function automatic logic [63:0] res_word(int k, int i, int s);
    if (fixed_en) return fixed_word;
    return {32'(k * 32'h01000193 ^ i * 32'h9E37 ^ s * 32'h85EB),
            32'(s * 32'hC2B2AE35 + i * 7 + k * 13 + 1)};
  endfunction

  initial begin : responder
    int cd;
    bit armed;
    armed = 1'b0;
    cd = 0;
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      core_done = 1'b0;
      if (done_req) begin core_done = 1'b1; done_req = 1'b0; snap++; end
      if (rd_req && resp_en && !rst) begin armed = 1'b1; cd = resp_delay; end
      if (armed) begin
        if (cd == 0) begin
          rd_valid = 1'b1;
          rd_data = res_word(int'(rd_field), int'(rd_idx), snap);
          armed = 1'b0;
          if (race_once) begin core_done = 1'b1; race_once = 1'b0; snap++; end
        end else cd--;
      end
    end
  end

  // Bridge-level model state
  int          m_err = 0, m_nb = 0, m_lk = 0, m_li = 0;
  bit          m_lv = 1'b0, m_go = 1'b0;
  logic [63:0] m_word = '0;

  task automatic bus_write(input logic [6:0] sel, input logic [8:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; addr = {sel, idx}; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] sel, input logic [8:0] idx,
                          output logic [31:0] d, output int waits);
    waits = 0;
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; addr = {sel, idx};
    #1;
    while (waitrequest && waits < 1000) begin
      waits++;
      @(posedge clk); #2;
    end
    if (waits >= 1000) begin
      n_vec++; n_err++;
      $display("FAIL read_bound sel=%h idx=%0d waitrequest still high after %0d cycles", sel, idx, waits);
    end
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; int w;
    repeat (3) @(negedge clk);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL rst_waitrequest got=%b exp=0", waitrequest); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    n_vec++; if ({go, freeze, rd_req} !== 3'b000) begin n_err++; $display("FAIL rst_ctrl got=%b exp=000", {go, freeze, rd_req}); end
    n_vec++; if (n_bodies !== 10'h0) begin n_err++; $display("FAIL rst_n_bodies got=%0d exp=0", n_bodies); end
    n_vec++; if (gap !== 32'h0) begin n_err++; $display("FAIL rst_gap got=%h exp=0", gap); end
    @(posedge clk); #1 rst = 1'b0;
    bus_read(7'h7F, 9'd0, d, w);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_status got=%h exp=0", d); end
    bus_read(7'h41, 9'd0, d, w);
    n_vec++; if (w !== 0 || d !== 32'h0) begin n_err++; $display("FAIL rst_out_read got waits=%0d data=%h exp waits=0 data=0", w, d); end
  endtask

  task automatic test_regs();
    logic [31:0] g;
    bus_write(7'h02, 9'd0, 32'd1000);
    n_vec++; if (n_bodies !== 10'd512) begin n_err++; $display("FAIL nb_clamp got=%0d exp=512", n_bodies); end
    bus_write(7'h02, 9'd0, 32'd512);
    n_vec++; if (n_bodies !== 10'd512) begin n_err++; $display("FAIL nb_max got=%0d exp=512", n_bodies); end
    bus_write(7'h02, 9'd0, 32'd25); m_nb = 25;
    n_vec++; if (n_bodies !== 10'd25) begin n_err++; $display("FAIL nb_25 got=%0d exp=25", n_bodies); end
    g = $urandom;
    bus_write(7'h03, 9'd0, g);
    n_vec++; if (gap !== g) begin n_err++; $display("FAIL gap got=%h exp=%h", gap, g); end
    bus_write(7'h01, 9'd0, 32'd1);
    n_vec++; if (freeze !== 1'b1) begin n_err++; $display("FAIL freeze_set got=%b exp=1", freeze); end
    bus_write(7'h01, 9'd0, 32'd0);
    n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL freeze_clr got=%b exp=0", freeze); end
    bus_write(7'h30, 9'd0, 32'hFFFF_FFFF);
    n_vec++; if ({go, freeze} !== 2'b00 || n_bodies !== 10'd25) begin n_err++; $display("FAIL unmapped_write got go/freeze=%b nb=%0d exp 00/25", {go, freeze}, n_bodies); end
  endtask

  task automatic test_field_commit();
    logic [75:0] e; int f, i; logic [31:0] lo, hi;
    we_q.delete();
    bus_write(7'h04, 9'd3, 32'h0000_0000);
    bus_write(7'h05, 9'd3, 32'h3FF0_0000);
    repeat (2) @(posedge clk);
    e = {3'd0, 9'd3, 64'h3FF0_0000_0000_0000};
    n_vec++; if (we_q.size() != 1 || we_q[0] !== e) begin n_err++; $display("FAIL commit_x count=%0d got=%h exp=%h", we_q.size(), (we_q.size() > 0) ? we_q[0] : 76'h0, e); end
    for (int n = 0; n < 8; n++) begin
      f = $urandom_range(0, 4); i = $urandom_range(0, 511); lo = $urandom; hi = $urandom;
      we_q.delete();
      bus_write(7'(4 + 2 * f), 9'(i), lo);
      bus_write(7'(5 + 2 * f), 9'(i), hi);
      repeat (2) @(posedge clk);
      e = {3'(f), 9'(i), hi, lo};
      n_vec++; if (we_q.size() != 1 || we_q[0] !== e) begin n_err++; $display("FAIL commit_rand count=%0d got=%h exp=%h", we_q.size(), (we_q.size() > 0) ? we_q[0] : 76'h0, e); end
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] d; int w;
    we_q.delete();
    bus_write(7'h06, 9'd1, $urandom);
    bus_write(7'h07, 9'd2, $urandom); m_err++;
    repeat (2) @(posedge clk);
    n_vec++; if (we_q.size() != 0) begin n_err++; $display("FAIL mismatch_commit got=%0d commits exp=0", we_q.size()); end
    bus_read(7'h7F, 9'd0, d, w);
    n_vec++; if (((d >> 3) & 32'hFF) !== 32'(m_err)) begin n_err++; $display("FAIL mismatch_err got=%0d exp=%0d", (d >> 3) & 32'hFF, m_err); end
  endtask

  task automatic test_read_miss();
    logic [31:0] d; int w, rq0;
    fixed_en = 1'b1; fixed_word = 64'h4034_0000_0000_0000; resp_delay = 3;
    rq0 = rdreq_cnt;
    bus_read(7'h41, 9'd0, d, w);
    m_lv = 1'b1; m_lk = 0; m_li = 0; m_word = fixed_word;
    n_vec++; if (w !== 5) begin n_err++; $display("FAIL miss_waits got=%0d exp=5", w); end
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL miss_lo got=%h exp=00000000", d); end
    n_vec++; if (rdreq_cnt - rq0 !== 1) begin n_err++; $display("FAIL miss_rdreq got=%0d exp=1", rdreq_cnt - rq0); end
    bus_read(7'h42, 9'd0, d, w);
    n_vec++; if (w !== 0 || d !== 32'h4034_0000) begin n_err++; $display("FAIL hit_hi got waits=%0d data=%h exp waits=0 data=40340000", w, d); end
    fixed_en = 1'b0;
  endtask

  task automatic test_done_race();
    logic [31:0] d; int w, rq0;
    resp_delay = 2; race_once = 1'b1;
    rq0 = rdreq_cnt;
    bus_read(7'h43, 9'd5, d, w);
    m_lv = 1'b1; m_lk = 1; m_li = 5; m_word = res_word(1, 5, snap);
    n_vec++; if (rdreq_cnt - rq0 !== 2) begin n_err++; $display("FAIL race_rdreq got=%0d exp=2", rdreq_cnt - rq0); end
    n_vec++; if (w !== 2 * 2 + 3) begin n_err++; $display("FAIL race_waits got=%0d exp=%0d", w, 2 * 2 + 3); end
    n_vec++; if (d !== m_word[31:0]) begin n_err++; $display("FAIL race_data got=%h exp=%h", d, m_word[31:0]); end
  endtask

  task automatic test_timeout();
    logic [31:0] d; int w, rq0;
    resp_en = 1'b0;
    rq0 = rdreq_cnt;
    bus_read(7'h41, 9'd7, d, w); m_err++;
    n_vec++; if (w !== RD_TIMEOUT + 1) begin n_err++; $display("FAIL tmo_waits got=%0d exp=%0d", w, RD_TIMEOUT + 1); end
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL tmo_data got=%h exp=0", d); end
    n_vec++; if (rdreq_cnt - rq0 !== 1) begin n_err++; $display("FAIL tmo_rdreq got=%0d exp=1", rdreq_cnt - rq0); end
    resp_en = 1'b1;
    bus_read(7'h7F, 9'd0, d, w);
    n_vec++; if (((d >> 3) & 32'hFF) !== 32'(m_err)) begin n_err++; $display("FAIL tmo_err got=%0d exp=%0d", (d >> 3) & 32'hFF, m_err); end
  endtask

  task automatic test_random_reads();
    logic [31:0] d, ed; int w, rq0, k, i, half, ew, erq; bit hit;
    for (int n = 0; n < 24; n++) begin
      if (m_lv && $urandom_range(0, 2) == 0) begin k = m_lk; i = m_li; end
      else begin k = $urandom_range(0, 1); i = $urandom_range(0, 30); end
      half = $urandom_range(0, 1);
      resp_delay = $urandom_range(0, 5);
      hit = m_lv && (m_lk == k) && (m_li == i);
      rq0 = rdreq_cnt;
      bus_read(7'(8'h41 + 2 * k + half), 9'(i), d, w);
      if (hit || i >= m_nb) begin
        ew = 0; erq = 0;
      end else begin
        ew = resp_delay + 2; erq = 1;
        m_lv = 1'b1; m_lk = k; m_li = i; m_word = res_word(k, i, snap);
      end
      ed = (hit || i < m_nb) ? (half != 0 ? m_word[63:32] : m_word[31:0]) : 32'h0;
      n_vec++; if (w !== ew) begin n_err++; $display("FAIL rnd_waits k=%0d idx=%0d got=%0d exp=%0d", k, i, w, ew); end
      n_vec++; if (d !== ed) begin n_err++; $display("FAIL rnd_data k=%0d idx=%0d half=%0d got=%h exp=%h", k, i, half, d, ed); end
      n_vec++; if (rdreq_cnt - rq0 !== erq) begin n_err++; $display("FAIL rnd_rdreq k=%0d idx=%0d got=%0d exp=%0d", k, i, rdreq_cnt - rq0, erq); end
    end
  endtask

  task automatic test_go_done();
    logic [31:0] d; int w;
    bus_write(7'h02, 9'd0, 32'd25); m_nb = 25;
    bus_write(7'h00, 9'd0, 32'd1);
    if (!m_go) m_lv = 1'b0;
    m_go = 1'b1;
    n_vec++; if (go !== 1'b1) begin n_err++; $display("FAIL go_set got=%b exp=1", go); end
    we_q.delete();
    bus_write(7'h04, 9'd2, $urandom); m_err++;
    repeat (2) @(posedge clk);
    n_vec++; if (we_q.size() != 0) begin n_err++; $display("FAIL go_drop got=%0d commits exp=0", we_q.size()); end
    bus_read(7'h7F, 9'd0, d, w);
    n_vec++; if (((d >> 3) & 32'hFF) !== 32'(m_err) || d[0] !== 1'b1) begin n_err++; $display("FAIL go_status got=%h exp err=%0d go=1", d, m_err); end
    bus_read(7'h40, 9'd0, d, w);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL done_before got=%h exp=0", d); end
    done_req = 1'b1;
    repeat (3) @(posedge clk);
    m_lv = 1'b0;
    bus_read(7'h40, 9'd0, d, w);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL done_set got=%h exp=1", d); end
    bus_write(7'h00, 9'd0, 32'd1);
    bus_read(7'h40, 9'd0, d, w);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL done_clr got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_fetch();
    resp_en = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; addr = {7'h41, 9'd1};
    repeat (3) @(posedge clk);
    #2;
    n_vec++; if (waitrequest !== 1'b1) begin n_err++; $display("FAIL midfetch_wait got=%b exp=1", waitrequest); end
    rst = 1'b1;
    #1;
    n_vec++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL async_rst_wait got=%b exp=0", waitrequest); end
    n_vec++; if (go !== 1'b0 || n_bodies !== 10'd0) begin n_err++; $display("FAIL async_rst_regs got go=%b nb=%0d exp 0/0", go, n_bodies); end
    chipselect = 1'b0; read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resp_en = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_field_commit();
    test_mismatch();
    test_read_miss();
    test_done_race();
    test_timeout();
    test_random_reads();
    test_go_done();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
